seg_scan_mux: RTL and testbench

//  Upstream driver for the hex-to-7-segment decoder on the 4-digit display.
//  - Holds a 16-bit value and time-multiplexes its four nibbles onto the single decoder.
//  - Drives the active-low anodes and the decimal point.
//  - Double-buffers host updates so the shown value changes only on a frame boundary (no tearing).

---
 rtl/seg_scan_mux.sv | 181 ++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed driver for a 4-digit hex display.
// Holds a 16-bit value and scans its nibbles onto one hex-to-7-segment decoder.
// It drives active-low anodes and an active-low decimal point.
// Host loads go through a shadow register and reach the display only on a frame
// boundary, so a frame never shows half of an old value and half of a new one.
// Optional build macro: LZ_BLANK_EN enables leading-zero suppression.
// Digit 0 is never blanked.

module seg_scan_mux #(
    parameter int DWELL_CYCLES = 100000,
    parameter int GUARD_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic        dp,
    output logic        busy,
    output logic        frame_tick
);

    localparam int            CW        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_VAL = CW'(GUARD_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [15:0]   disp_q, disp_d;
    logic [3:0]    disp_dp_q, disp_dp_d;
    logic [3:0]    nib_q, nib_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q, dp_d;
    logic          busy_q, busy_d;
    logic          frame_tick_q, frame_tick_d;

    logic          cnt_wrap_s;
    logic          frame_s;
    logic [3:0]    blank_s;
    logic [3:0]    nib_sel_s;
    logic          lit_s;

    // Dwell counter and digit index; a frame ends when digit 3's dwell wraps.
    always_comb begin
        cnt_wrap_s = (cnt_q == CNT_LAST);
        frame_s    = cnt_wrap_s && (idx_q == 2'd3);
        if (cnt_wrap_s) begin
            cnt_d = {CW{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end
    end

    // Load FSM next state: a boundary commits the old shadow before a coincident load overwrites it.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;
        if (frame_s && (state_q == ST_PEND)) begin
            disp_d    = shadow_q;
            disp_dp_d = shadow_dp_q;
            state_d   = ST_IDLE;
        end else begin
            disp_d    = disp_q;
            disp_dp_d = disp_dp_q;
        end
        if (load) begin
            shadow_d    = value_in;
            shadow_dp_d = dp_in;
            state_d     = ST_PEND;
        end else begin
            shadow_d    = shadow_q;
            shadow_dp_d = shadow_dp_q;
        end
    end

`ifdef LZ_BLANK_EN
    // Leading-zero suppression: digit k is dark when nibbles k..3 are all zero.
    always_comb begin
        blank_s    = 4'b0000;
        blank_s[3] = (disp_q[15:12] == 4'h0);
        blank_s[2] = (disp_q[15:8] == 8'h00);
        blank_s[1] = (disp_q[15:4] == 12'h000);
    end
`else
    // No suppression: every enabled digit lights, leading zeros included.
    always_comb begin
        blank_s = 4'b0000;
    end
`endif

    // Output decode for the digit currently in its dwell, registered below.
    always_comb begin
        case (idx_q)
            2'd0:    nib_sel_s = disp_q[3:0];
            2'd1:    nib_sel_s = disp_q[7:4];
            2'd2:    nib_sel_s = disp_q[11:8];
            2'd3:    nib_sel_s = disp_q[15:12];
            default: nib_sel_s = 4'h0;
        endcase
        nib_d        = nib_sel_s;
        lit_s        = (cnt_q >= GUARD_VAL) && digit_en[idx_q] && !blank_s[idx_q];
        an_d         = 4'hF;
        if (lit_s) begin
            an_d[idx_q] = 1'b0;
            dp_d        = ~disp_dp_q[idx_q];
        end else begin
            an_d        = 4'hF;
            dp_d        = 1'b1;
        end
        busy_d       = (state_d == ST_PEND);
        frame_tick_d = frame_s;
    end

    // Load FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan position, shadow and displayed-value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= {CW{1'b0}};
            idx_q       <= 2'd0;
            shadow_q    <= 16'h0000;
            shadow_dp_q <= 4'h0;
            disp_q      <= 16'h0000;
            disp_dp_q   <= 4'h0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
        end
    end

    // Registered display and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_q        <= 4'h0;
            an_q         <= 4'hF;
            dp_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            nib_q        <= nib_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            busy_q       <= busy_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign nib        = nib_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign busy       = busy_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DWELL_CYCLES=4, GUARD_CYCLES=1.
// Edge n counts rising edges since reset release. Outputs sampled after edge n
// reflect the scan position before that edge: dwell cycle (n-1)%4, digit ((n-1)/4)%4.
// A frame is 16 clocks, and frame boundaries fall on edges that are multiples of 16.
// Expected values follow LZ_BLANK_EN when that macro is defined.

module tb_seg_scan_mux;

    localparam int DWELL = 4;
    localparam int GUARD = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  nib;
    logic [3:0]  an;
    logic        dp;
    logic        busy;
    logic        frame_tick;

    int          checks   = 0;
    int          failures = 0;
    int          n;
    int          phase;
    logic [15:0] exp_disp;
    logic [3:0]  exp_dpv;
    logic [3:0]  exp_en;
    logic        exp_busy;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .DWELL_CYCLES(DWELL),
        .GUARD_CYCLES(GUARD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .nib       (nib),
        .an        (an),
        .dp        (dp),
        .busy      (busy),
        .frame_tick(frame_tick)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h expected=%h", tag, n, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_an"}, {12'h000, an}, 16'h000F);
        chk({tag, "_dp"}, {15'h0000, dp}, 16'h0001);
        chk({tag, "_nib"}, {12'h000, nib}, 16'h0000);
        chk({tag, "_busy"}, {15'h0000, busy}, 16'h0000);
        chk({tag, "_tick"}, {15'h0000, frame_tick}, 16'h0000);
    endtask

    task automatic check_outputs();
        int         c;
        int         i;
        logic       blank;
        logic       lit;
        logic [3:0] want_an;
        logic [3:0] want_nib;
        logic       want_dp;
        logic       want_tick;
        c     = (n - 1) % 4;
        i     = ((n - 1) / 4) % 4;
        blank = 1'b0;
`ifdef LZ_BLANK_EN
        if ((i > 0) && ((exp_disp >> (4 * i)) == 16'h0000)) blank = 1'b1;
`endif
        lit       = (c >= GUARD) && exp_en[i] && !blank;
        want_an   = 4'hF;
        if (lit) want_an[i] = 1'b0;
        want_nib  = exp_disp[4 * i +: 4];
        want_dp   = lit ? ~exp_dpv[i] : 1'b1;
        want_tick = ((n % 16) == 0);
        chk("nib", {12'h000, nib}, {12'h000, want_nib});
        chk("an", {12'h000, an}, {12'h000, want_an});
        chk("dp", {15'h0000, dp}, {15'h0000, want_dp});
        chk("busy", {15'h0000, busy}, {15'h0000, exp_busy});
        chk("frame_tick", {15'h0000, frame_tick}, {15'h0000, want_tick});
    endtask

    task automatic run_to(input int last);
        while (n < last) begin
            load = 1'b0;
            if (phase == 0) begin
                case (n + 1)
                    17:  begin load = 1'b1; value_in = 16'h1234; dp_in = 4'b0100; end
                    38:  begin load = 1'b1; value_in = 16'hAAAA; dp_in = 4'b1111; end
                    42:  begin load = 1'b1; value_in = 16'h5555; dp_in = 4'b0001; end
                    52:  begin load = 1'b1; value_in = 16'h0F0F; dp_in = 4'b0000; end
                    64:  begin load = 1'b1; value_in = 16'h0050; dp_in = 4'b1000; end
                    81:  digit_en = 4'b0101;
                    97:  digit_en = 4'hF;
                    100: begin load = 1'b1; value_in = 16'h0000; dp_in = 4'b0010; end
                    default: ;
                endcase
            end
            step();
            if (phase == 0) begin
                case (n)
                    17, 38, 52, 100: exp_busy = 1'b1;
                    32, 48, 80, 112: exp_busy = 1'b0;
                    81:  exp_en = 4'b0101;
                    97:  exp_en = 4'hF;
                    default: ;
                endcase
            end
            check_outputs();
            if (phase == 0) begin
                case (n)
                    32:  begin exp_disp = 16'h1234; exp_dpv = 4'b0100; end
                    48:  begin exp_disp = 16'h5555; exp_dpv = 4'b0001; end
                    64:  begin exp_disp = 16'h0F0F; exp_dpv = 4'b0000; end
                    80:  begin exp_disp = 16'h0050; exp_dpv = 4'b1000; end
                    112: begin exp_disp = 16'h0000; exp_dpv = 4'b0010; end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0000;
        dp_in    = 4'h0;
        digit_en = 4'hF;
        n        = 0;
        phase    = 0;
        exp_disp = 16'h0000;
        exp_dpv  = 4'h0;
        exp_en   = 4'hF;
        exp_busy = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        run_to(128);

        // Load, then reset while the value is still pending: the shadow must be lost.
        load     = 1'b1;
        value_in = 16'hBEEF;
        dp_in    = 4'hF;
        step();
        load = 1'b0;
        chk("busy_before_reset", {15'h0000, busy}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        n        = 0;
        phase    = 1;
        exp_disp = 16'h0000;
        exp_dpv  = 4'h0;
        exp_en   = 4'hF;
        exp_busy = 1'b0;
        run_to(32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
